// File: rtl/mips_pkg.sv
// +------------------------------------------------------------------+
// | Module   : mips_pkg                                               |
// | Purpose  : Shared widths, byte-enable constants and ME FSM states |
// | Revision : 1.0 - initial release                                  |
// +------------------------------------------------------------------+
`default_nettype none

package mips_pkg;

    localparam int DATA_W = 32;
    localparam int REG_W  = 5;

    localparam logic [3:0] BE_WORD = 4'b1111;
    localparam logic [3:0] BE_NONE = 4'b0000;

    typedef enum logic [0:0] {
        ME_IDLE = 1'b0,
        ME_WAIT = 1'b1
    } meState_t;

endpackage

`default_nettype wire

// File: rtl/byte_lane_steer.sv
// +------------------------------------------------------------------+
// | Module   : byte_lane_steer                                        |
// | Purpose  : Byte enables, SB lane replication, LB sign extension   |
// | Revision : 1.0 - initial release                                  |
// +------------------------------------------------------------------+
`default_nettype none

module byte_lane_steer
    import mips_pkg::*;
(
    input  logic [1:0]        Addr,
    input  logic              LoadB,
    input  logic              StoreB,
    input  logic [DATA_W-1:0] StoreDat,
    input  logic [DATA_W-1:0] RdDat,
    output logic [3:0]        ByteEn,
    output logic [DATA_W-1:0] WrDat,
    output logic [DATA_W-1:0] LoadDat
);

    logic [7:0] w_rdByte;

    always_comb begin
        w_rdByte = RdDat[7:0];
        case (Addr)
            2'd0:    w_rdByte = RdDat[7:0];
            2'd1:    w_rdByte = RdDat[15:8];
            2'd2:    w_rdByte = RdDat[23:16];
            default: w_rdByte = RdDat[31:24];
        endcase
    end

    // Little-endian: lane 0 is bits [7:0].
    assign ByteEn  = (LoadB | StoreB) ? (4'b0001 << Addr) : BE_WORD;
    assign WrDat   = StoreB ? {4{StoreDat[7:0]}} : StoreDat;
    assign LoadDat = LoadB ? {{(DATA_W-8){w_rdByte[7]}}, w_rdByte} : RdDat;

endmodule

`default_nettype wire

// File: rtl/memory_stage.sv
// +------------------------------------------------------------------+
// | Module   : memory_stage                                           |
// | Purpose  : MIPS ME stage: data-memory handshake, stall, ME regs   |
// | Option   : MEM_ALIGN_CHK_EN adds the AddrErr_ME misalign output   |
// | Revision : 1.0 - initial release                                  |
// +------------------------------------------------------------------+
`default_nettype none

module memory_stage
    import mips_pkg::*;
#(
    parameter int ACK_TIMEOUT = 255,
    parameter int CNT_W       = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] Result_EX,
    input  logic [DATA_W-1:0] WrDat_EX,
    input  logic [REG_W-1:0]  WriteReg_EX,
    input  logic              RegWrite_EX,
    input  logic              MemToReg_EX,
    input  logic              MemWrite_EX,
    input  logic              LoadB_EX,
    input  logic              StoreB_EX,
    input  logic              InstrVal_EX,
    output logic              DmReq,
    output logic              DmWe,
    output logic [DATA_W-1:0] DmAddr,
    output logic [DATA_W-1:0] DmWrDat,
    output logic [3:0]        DmByteEn,
    input  logic [DATA_W-1:0] DmRdDat,
    input  logic              DmAck,
    output logic              MemStall_ME,
    output logic              BusErr_ME,
`ifdef MEM_ALIGN_CHK_EN
    output logic              AddrErr_ME,
`endif
    output logic [DATA_W-1:0] ResultRdDat_ME,
    output logic [REG_W-1:0]  WriteReg_ME,
    output logic              RegWrite_ME,
    output logic              InstrVal_ME
);

    localparam logic [CNT_W-1:0] c_ACK_TIMEOUT = CNT_W'(ACK_TIMEOUT);
    localparam logic [CNT_W-1:0] c_CNT_ONE     = CNT_W'(1);
    localparam bit               c_TIMEOUT_EN  = (ACK_TIMEOUT != 0);

    meState_t          r_state;
    meState_t          w_nextState;
    logic [CNT_W-1:0]  r_cnt;

    logic [DATA_W-1:0] r_reqAddr;
    logic [DATA_W-1:0] r_reqWrDat;
    logic [REG_W-1:0]  r_reqWriteReg;
    logic              r_reqWe;
    logic              r_reqLoadB;
    logic              r_reqStoreB;
    logic              r_reqMemToReg;
    logic              r_reqRegWrite;
    logic              r_reqInstrVal;

    logic              w_inWait;
    logic              w_memOp;
    logic              w_misalign;
    logic              w_issue;
    logic              w_dmReqRaw;
    logic              w_stall;
    logic              w_timeout;
    logic              w_latchReq;
    logic              w_accessDone;

    logic [DATA_W-1:0] w_addr;
    logic [DATA_W-1:0] w_wrDat;
    logic [REG_W-1:0]  w_writeReg;
    logic              w_we;
    logic              w_loadB;
    logic              w_storeB;
    logic              w_memToReg;
    logic              w_regWrite;
    logic              w_instrVal;

    logic [3:0]        w_byteEn;
    logic [DATA_W-1:0] w_steerWrDat;
    logic [DATA_W-1:0] w_loadDat;

    assign w_inWait = (r_state == ME_WAIT);
    assign w_memOp  = InstrVal_EX & (MemToReg_EX | MemWrite_EX);

`ifdef MEM_ALIGN_CHK_EN
    assign w_misalign = ~w_inWait & w_memOp & ~LoadB_EX & ~StoreB_EX
                      & (Result_EX[1:0] != 2'b00);
`else
    assign w_misalign = 1'b0;
`endif

    assign w_issue = w_memOp & ~w_misalign;

    // While waiting the request is replayed from the latched copy, not from EX.
    assign w_addr     = w_inWait ? r_reqAddr     : Result_EX;
    assign w_wrDat    = w_inWait ? r_reqWrDat    : WrDat_EX;
    assign w_writeReg = w_inWait ? r_reqWriteReg : WriteReg_EX;
    assign w_we       = w_inWait ? r_reqWe       : MemWrite_EX;
    assign w_loadB    = w_inWait ? r_reqLoadB    : LoadB_EX;
    assign w_storeB   = w_inWait ? r_reqStoreB   : StoreB_EX;
    assign w_memToReg = w_inWait ? r_reqMemToReg : MemToReg_EX;
    assign w_regWrite = w_inWait ? r_reqRegWrite : RegWrite_EX;
    assign w_instrVal = w_inWait ? r_reqInstrVal : InstrVal_EX;

    byte_lane_steer u_steer (
        .Addr     (w_addr[1:0]),
        .LoadB    (w_loadB),
        .StoreB   (w_storeB),
        .StoreDat (w_wrDat),
        .RdDat    (DmRdDat),
        .ByteEn   (w_byteEn),
        .WrDat    (w_steerWrDat),
        .LoadDat  (w_loadDat)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ME_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_nextState;
            if (w_latchReq)
                r_cnt <= '0;
            else if (w_inWait)
                r_cnt <= r_cnt + c_CNT_ONE;
        end
    end

    always_comb begin
        w_nextState = r_state;
        w_dmReqRaw  = 1'b0;
        w_stall     = 1'b0;
        w_timeout   = 1'b0;
        w_latchReq  = 1'b0;
        case (r_state)
            ME_IDLE: begin
                if (w_issue) begin
                    w_dmReqRaw = 1'b1;
                    if (!DmAck) begin
                        w_stall     = 1'b1;
                        w_latchReq  = 1'b1;
                        w_nextState = ME_WAIT;
                    end
                end
            end
            ME_WAIT: begin
                w_dmReqRaw = 1'b1;
                if (DmAck) begin
                    w_nextState = ME_IDLE;
                end else if (c_TIMEOUT_EN && (r_cnt == c_ACK_TIMEOUT)) begin
                    w_timeout   = 1'b1;
                    w_nextState = ME_IDLE;
                end else begin
                    w_stall = 1'b1;
                end
            end
            default: w_nextState = ME_IDLE;
        endcase
    end

    assign w_accessDone = w_dmReqRaw & DmAck;

    // Reset kills the request in the same cycle so an in-flight access is abandoned.
    assign DmReq       = w_dmReqRaw & ~reset;
    assign MemStall_ME = w_stall & ~reset;
    assign DmWe        = DmReq & w_we;
    assign DmAddr      = {w_addr[DATA_W-1:2], 2'b00};
    assign DmWrDat     = w_steerWrDat;
    assign DmByteEn    = DmReq ? w_byteEn : BE_NONE;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_reqAddr     <= '0;
            r_reqWrDat    <= '0;
            r_reqWriteReg <= '0;
            r_reqWe       <= 1'b0;
            r_reqLoadB    <= 1'b0;
            r_reqStoreB   <= 1'b0;
            r_reqMemToReg <= 1'b0;
            r_reqRegWrite <= 1'b0;
            r_reqInstrVal <= 1'b0;
        end else if (w_latchReq) begin
            r_reqAddr     <= Result_EX;
            r_reqWrDat    <= WrDat_EX;
            r_reqWriteReg <= WriteReg_EX;
            r_reqWe       <= MemWrite_EX;
            r_reqLoadB    <= LoadB_EX;
            r_reqStoreB   <= StoreB_EX;
            r_reqMemToReg <= MemToReg_EX;
            r_reqRegWrite <= RegWrite_EX;
            r_reqInstrVal <= InstrVal_EX;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ResultRdDat_ME <= '0;
            WriteReg_ME    <= '0;
            RegWrite_ME    <= 1'b0;
            InstrVal_ME    <= 1'b0;
            BusErr_ME      <= 1'b0;
        end else begin
            BusErr_ME <= w_timeout;
            if (!w_stall) begin
                ResultRdDat_ME <= (w_accessDone & w_memToReg) ? w_loadDat : w_addr;
                WriteReg_ME    <= w_writeReg;
                RegWrite_ME    <= w_regWrite & ~w_timeout & ~w_misalign;
                InstrVal_ME    <= w_instrVal;
            end
        end
    end

`ifdef MEM_ALIGN_CHK_EN
    always_ff @(posedge clk) begin
        if (reset)
            AddrErr_ME <= 1'b0;
        else
            AddrErr_ME <= w_misalign;
    end
`endif

endmodule

`default_nettype wire
